// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch and load/store requesters.
// Define ARB_STARVE_GUARD_EN to enable the fetch starvation guard (default: strict data priority).
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_size,
  input  logic [DATA_W-1:0] m_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT or STARVE_LIMIT out of range");
  end

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;
  logic       cap_i, cap_d;
  logic       fetch_wins;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign fetch_wins = (starve_cnt >= STARVE_TH);
`else
  assign fetch_wins = 1'b0;
`endif

  // Grants are gated by reset so every output reads zero while reset is held.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    cap_i       = 1'b0;
    cap_d       = 1'b0;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_size      = '0;
    unique case (state)
      IDLE: begin
        if (!reset) begin
          if (i_req && (!d_req || fetch_wins)) begin
            i_gnt       = 1'b1;
            m_en        = 1'b1;
            m_addr      = i_addr;
            m_size      = 2'd2;
            state_nxt   = WAIT_I;
            lat_cnt_nxt = LAT_INIT;
          end else if (d_req) begin
            d_gnt   = 1'b1;
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_size  = d_size;
            if (!d_we) begin
              state_nxt   = WAIT_D;
              lat_cnt_nxt = LAT_INIT;
            end
          end
        end
      end
      WAIT_I, WAIT_D: begin
        if (lat_cnt == 3'd0) begin
          cap_i     = (state == WAIT_I);
          cap_d     = (state == WAIT_D);
          state_nxt = IDLE;
        end else begin
          lat_cnt_nxt = lat_cnt - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_cnt_nxt;
      i_rvalid <= cap_i;
      d_rvalid <= cap_d;
      if (cap_i) i_rdata <= m_rdata;
      if (cap_d) d_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed tables, corner sequences and a random phase
// against a cycle-count reference model (honours ARB_STARVE_GUARD_EN).
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SLIM = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, m_rdata, m_wdata, i_rdata, d_rdata;
  logic [1:0]    d_size, m_size;
  logic          i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_rdata(m_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Memory environment: contents plus a read delay line of LAT stages.
  logic [31:0] mem [logic [31:0]];
  bit          dl_v [LAT];
  logic [31:0] dl_d [LAT];

  // Reference model: one outstanding read, known return cycle.
  bit          pend_v, pend_f;
  int          pend_ret;
  logic [31:0] pend_data, e_i_rdata, e_d_rdata;
  int          starve;

  // Observations of the last cycle, used by directed checks and requester behaviour.
  bit          o_ig, o_dg, o_en, o_we, o_irv, o_drv;
  logic [1:0]  o_sz;
  logic [31:0] o_addr, o_irdata, o_drdata;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    bit          e_irv, e_drv, e_ig, e_dg, e_en, e_we, free;
    logic [31:0] e_addr, e_wd;
    logic [1:0]  e_sz;
    m_rdata = dl_v[LAT-1] ? dl_d[LAT-1] : $urandom;
    @(negedge clock);
    #1;
    e_irv = pend_v && pend_f && (pend_ret == cyc);
    e_drv = pend_v && !pend_f && (pend_ret == cyc);
    if (e_irv) e_i_rdata = pend_data;
    if (e_drv) e_d_rdata = pend_data;
    free = !pend_v || (cyc >= pend_ret);
    e_ig = 1'b0;
    e_dg = 1'b0;
    if (!reset && free) begin
      if (i_req && (!d_req || (GUARD && starve >= SLIM))) e_ig = 1'b1;
      else if (d_req) e_dg = 1'b1;
    end
    e_en   = e_ig | e_dg;
    e_we   = e_dg & d_we;
    e_addr = e_ig ? i_addr : (e_dg ? d_addr : 32'h0);
    e_sz   = e_ig ? 2'd2 : (e_dg ? d_size : 2'd0);
    e_wd   = e_we ? d_wdata : 32'h0;
    chk("i_gnt", i_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("m_en", m_en, e_en);
    chk("m_we", m_we, e_we);
    chk("m_addr", m_addr, e_addr);
    chk("m_size", m_size, e_sz);
    if (e_we || !e_en) chk("m_wdata", m_wdata, e_wd);
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("i_rdata", i_rdata, e_i_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    o_ig = i_gnt; o_dg = d_gnt; o_en = m_en; o_we = m_we; o_irv = i_rvalid; o_drv = d_rvalid;
    o_sz = m_size; o_addr = m_addr; o_irdata = i_rdata; o_drdata = d_rdata;
    if (reset) begin
      pend_v = 1'b0; e_i_rdata = '0; e_d_rdata = '0; starve = 0;
    end else begin
      if (e_irv || e_drv) pend_v = 1'b0;
      if (e_ig || (e_dg && !d_we)) begin
        pend_v = 1'b1; pend_f = e_ig; pend_ret = cyc + LAT + 1; pend_data = mem_rd(e_addr);
      end
      starve = (!i_req || e_ig) ? 0 : ((starve < 15) ? starve + 1 : 15);
    end
    if (m_en && m_we) mem[m_addr] = m_wdata;
    for (int k = LAT - 1; k > 0; k--) begin
      dl_v[k] = dl_v[k-1];
      dl_d[k] = dl_d[k-1];
    end
    dl_v[0] = m_en && !m_we;
    dl_d[0] = mem_rd(m_addr);
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  typedef struct packed {
    bit ir, dr, dw;
    bit xig, xdg, xen, xwe, xirv, xdrv;
  } vec_t;
  vec_t tbl [14];

  initial begin
    int first, cnt_en, cnt_ig, cnt_irv, cnt_drv;
    bit got;
    tbl[0]  = '{1,1,0, 0,1,1,0,0,0};
    tbl[1]  = '{1,0,0, 0,0,0,0,0,0};
    tbl[2]  = '{1,0,0, 0,0,0,0,0,0};
    tbl[3]  = '{1,0,0, 1,0,1,0,0,1};
    tbl[4]  = '{0,0,0, 0,0,0,0,0,0};
    tbl[5]  = '{0,0,0, 0,0,0,0,0,0};
    tbl[6]  = '{0,0,0, 0,0,0,0,1,0};
    tbl[7]  = '{0,0,0, 0,0,0,0,0,0};
    tbl[8]  = '{0,1,1, 0,1,1,1,0,0};
    tbl[9]  = '{0,1,0, 0,1,1,0,0,0};
    tbl[10] = '{0,0,0, 0,0,0,0,0,0};
    tbl[11] = '{0,0,0, 0,0,0,0,0,0};
    tbl[12] = '{0,0,0, 0,0,0,0,0,1};
    tbl[13] = '{0,0,0, 0,0,0,0,0,0};

    for (int k = 0; k < LAT; k++) begin dl_v[k] = 1'b0; dl_d[k] = '0; end
    pend_v = 1'b0; pend_f = 1'b0; pend_ret = 0; pend_data = '0;
    e_i_rdata = '0; e_d_rdata = '0; starve = 0;
    mem[32'h0100_0000] = 32'h0000_0013;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0100_0000; d_addr = 32'h0100_0040; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
    m_rdata = '0;

    // Reset state
    cycle(); cycle();
    chk("reset_i_rdata", o_irdata, 32'h0);
    chk("reset_d_rdata", o_drdata, 32'h0);
    chk("reset_m_en", o_en, 32'h0);
    reset = 1'b0;
    idle(2);

    // Lone fetch
    cnt_irv = 0;
    for (int k = 0; k < 5; k++) begin
      i_req = (k == 0);
      cycle();
      if (k == 0) begin
        chk("lf_gnt", o_ig, 32'h1);
        chk("lf_size", o_sz, 32'h2);
        chk("lf_addr", o_addr, 32'h0100_0000);
      end
      if (k == LAT + 1) begin
        chk("lf_rvalid", o_irv, 32'h1);
        chk("lf_rdata", o_irdata, 32'h0000_0013);
      end
      cnt_irv += o_irv;
    end
    chk("lf_rvalid_count", cnt_irv, 32'h1);

    // Simultaneous requests, then store followed by load
    for (int r = 0; r < 14; r++) begin
      i_req = tbl[r].ir; d_req = tbl[r].dr; d_we = tbl[r].dw;
      cycle();
      chk("tbl_i_gnt", o_ig, tbl[r].xig);
      chk("tbl_d_gnt", o_dg, tbl[r].xdg);
      chk("tbl_m_en", o_en, tbl[r].xen);
      chk("tbl_m_we", o_we, tbl[r].xwe);
      chk("tbl_i_rvalid", o_irv, tbl[r].xirv);
      chk("tbl_d_rvalid", o_drv, tbl[r].xdrv);
    end
    chk("st_ld_data", o_drdata, 32'hDEAD_BEEF);
    chk("fetch_data_kept", o_irdata, 32'h0000_0013);
    idle(2);

    // Stores hold d_req high while fetch waits
    got = 1'b0; first = -1;
    d_addr = 32'h0100_0080; d_size = 2'd2;
    for (int k = 0; k < 12; k++) begin
      i_req = !got; d_req = 1'b1; d_we = 1'b1; d_wdata = $urandom;
      cycle();
      if (o_ig && !got) begin got = 1'b1; first = k; end
    end
    chk("starve_first_gnt", first, GUARD ? 32'd4 : 32'hFFFF_FFFF);
    idle(5);

    // Fetch request dropped during WAIT_D
    cnt_en = 0; cnt_ig = 0; cnt_irv = 0; cnt_drv = 0;
    d_addr = 32'h0100_0040;
    for (int k = 0; k < 7; k++) begin
      d_req = (k == 0); d_we = 1'b0; i_req = (k == 1);
      cycle();
      cnt_en += o_en; cnt_ig += o_ig; cnt_irv += o_irv; cnt_drv += o_drv;
    end
    chk("drop_m_en_count", cnt_en, 32'h1);
    chk("drop_i_gnt_count", cnt_ig, 32'h0);
    chk("drop_i_rvalid_count", cnt_irv, 32'h0);
    chk("drop_d_rvalid_count", cnt_drv, 32'h1);
    idle(2);

    // Reset held three cycles during WAIT_D
    cnt_drv = 0; cnt_en = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0000;
    cycle();
    chk("rst_load_gnt", o_dg, 32'h1);
    d_req = 1'b0; reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      cnt_en += o_en; cnt_drv += o_drv;
      if (k == 1) begin
        chk("rst_i_rdata", o_irdata, 32'h0);
        chk("rst_d_rdata", o_drdata, 32'h0);
      end
    end
    reset = 1'b0; d_req = 1'b1; d_addr = 32'h0100_0040;
    cycle();
    chk("rst_release_gnt", o_dg, 32'h1);
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin cycle(); if (k < 2) cnt_drv += o_drv; end
    chk("rst_m_en_count", cnt_en, 32'h0);
    chk("rst_no_stale_rvalid", cnt_drv, 32'h0);
    chk("rst_new_load_rvalid", o_drv, 32'h1);
    idle(2);

    // Randomised requesters obeying the hold-until-grant protocol
    for (int k = 0; k < 800; k++) begin
      if (i_req && o_ig) i_req = 1'b0;
      else if (i_req && $urandom_range(0, 15) == 0) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = 32'h0100_0000 + 32'($urandom_range(0, 7)) * 4;
      end
      if (d_req && o_dg) d_req = 1'b0;
      else if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1) == 1; d_wdata = $urandom;
        d_size = 2'($urandom_range(0, 2));
        d_addr = 32'h0100_0000 + 32'($urandom_range(0, 7)) * 4;
      end
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of the RV32I core. Arbitrates per access, drives the memory port for the granted requester, tracks the one outstanding read through a fixed memory latency, and returns read data to the requester that issued it. Sits between the PC/fetch logic and the load/store path on one side and the unified memory model on the other.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from issue to valid `m_rdata` (legal 1..4)
- STARVE_LIMIT, 4, fetch wait cycles before forced fetch grant (legal 1..15)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch read request, held until `i_gnt`
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  one-cycle pulse, `i_rdata` valid
- i_rdata  out  DATA_W  fetch data, held until next fetch return
- d_req  in  1  data request, held until `d_gnt`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_size  in  2  access size (0 byte, 1 half, 2 word), passed through
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse, `d_rdata` valid (loads only)
- d_rdata  out  DATA_W  load data, held until next load return
- m_en  out  1  memory access this cycle
- m_we  out  1  memory write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_size  out  2  memory access size (fetch always 2)
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue

## Operation
- States: IDLE, WAIT_I, WAIT_D. Latency counter `lat_cnt` (3 bits), owner implied by state.
- IDLE: arbitrate combinationally among `i_req`, `d_req`; grant at most one per cycle.
- Priority: data over fetch, except when starvation guard forces fetch (see Configuration).
- Grant cycle: `*_gnt`=1, `m_en`=1, `m_*` driven from granted requester; ungranted cycles drive `m_en`=`m_we`=0, `m_addr`=`m_wdata`=0, `m_size`=0.
- Store grant: write completes in grant cycle; no rvalid; state stays IDLE; next grant possible next cycle.
- Read grant (fetch or load): state -> WAIT_I/WAIT_D, `lat_cnt` loaded with MEM_LAT-1.
- WAIT_x: no grants; decrement `lat_cnt` each cycle; when `lat_cnt`=0, capture `m_rdata` into owner's rdata register, go IDLE.
- Cycle after capture: owner's `*_rvalid`=1 for exactly one cycle; arbiter may grant in same cycle.
- Requester may drop `*_req` before grant; no side effect. Inputs sampled only in grant cycle.
- Other requester's rdata register is never disturbed.

## Timing
- Reset: state IDLE, `lat_cnt`=0, starve counter 0, all outputs 0 (incl. both rdata registers).
- Grant: 0 cycles (combinational from req in IDLE).
- Read return: issue at cycle t -> `*_rvalid` at t+MEM_LAT+1; back-to-back read issue interval MEM_LAT+1.
- Store throughput: one per cycle when fetch not granted.
- Simultaneous `i_req`/`d_req` in IDLE: `d_gnt`=1, `i_gnt`=0 (unless guard forces fetch).
- Reset asserted during WAIT_x: outstanding read discarded, no rvalid pulse, all state to reset values next cycle.
- `*_gnt` never asserted outside IDLE; `i_gnt` and `d_gnt` never both 1.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: 4-bit starve counter increments each cycle `i_req`=1 and `i_gnt`=0 in IDLE or WAIT states (saturating), clears on `i_gnt` or `i_req`=0; when counter >= STARVE_LIMIT, fetch wins next IDLE arbitration over data.
- Not defined: strict fixed data-over-fetch priority; no counter logic; fetch may starve indefinitely.

## Test plan
- Reset: hold reset 3 cycles mid-WAIT_D -> all outputs 0, no `d_rvalid`, state IDLE after release.
- Lone fetch, MEM_LAT=1, i_addr=0x0100_0000, m_rdata=0x0000_0013 -> `i_gnt` cycle 0, `m_size`=2, `i_rvalid`=1 and `i_rdata`=0x13 at cycle 2.
- Store then load, d_addr=0x0100_0040, d_wdata=0xDEAD_BEEF, d_size=2 -> store granted cycle 0 with `m_we`=1, load granted cycle 1, `d_rvalid` cycle 3 with memory's data; `i_rdata` unchanged.
- Simultaneous i_req/d_req (load), MEM_LAT=2 -> `d_gnt` cycle 0, `i_gnt` cycle 3, `d_rvalid` cycle 3, `i_rvalid` cycle 6.
- Guard on, STARVE_LIMIT=4, d_req stuck high with stores, i_req high -> `i_gnt` after exactly 4 denied cycles; guard off -> `i_gnt` never asserted.
- Fetch req dropped before grant during WAIT_D -> no `i_gnt`, no `i_rvalid`, `m_en` only for the load.
